// File: rtl/multdiv_unit_if.sv
// ============================================================================
// Module      : multdiv_unit_if
// Description : Handshake and result bundle between the mips32 controller and
//               the iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface multdiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/multdiv_unit.sv
// ============================================================================
// Module      : multdiv_unit
// Description : Iterative shift-add multiply / restoring divide, one bit per
//               clock. MULTDIV_SIGNED_EN adds signed MULT/DIV (op[1]=1).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic     clk,
    input  wire logic     reset,
    multdiv_unit_if.slave bus
);

    localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_is_div;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH:0]   r_acc;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_dz;

    logic [WIDTH-1:0]   w_a_in;
    logic [WIDTH-1:0]   w_b_in;
    logic [WIDTH:0]     w_rem_shift;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_lo;

`ifdef MULTDIV_SIGNED_EN
    logic               r_neg_q;
    logic               r_neg_r;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [2*WIDTH-1:0] w_prod_u;

    always_comb begin
        w_a_neg = bus.op[1] & bus.a[WIDTH-1];
        w_b_neg = bus.op[1] & bus.b[WIDTH-1];
        w_a_in  = w_a_neg ? -bus.a : bus.a;
        w_b_in  = w_b_neg ? -bus.b : bus.b;
    end
`else
    always_comb begin
        w_a_in = bus.a;
        w_b_in = bus.b;
    end
`endif

    // Upper WIDTH+1 bits: partial product / remainder; lower WIDTH bits:
    // multiplier being shifted out / quotient being shifted in.
    always_comb begin
        w_rem_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_trial     = w_rem_shift - {1'b0, r_b};
        w_mul_sum   = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_b} : '0);
        if (r_is_div) begin
            w_acc_nxt = {(w_trial[WIDTH] ? w_rem_shift : w_trial),
                         r_acc[WIDTH-2:0], ~w_trial[WIDTH]};
        end else begin
            w_acc_nxt = {1'b0, w_mul_sum, r_acc[WIDTH-1:1]};
        end
    end

`ifdef MULTDIV_SIGNED_EN
    // A zero divisor keeps the all-ones quotient regardless of operand signs.
    always_comb begin
        w_prod_u = w_acc_nxt[2*WIDTH-1:0];
        w_hi     = w_prod_u[2*WIDTH-1:WIDTH];
        w_lo     = w_prod_u[WIDTH-1:0];
        if (!r_is_div) begin
            if (r_neg_q) begin
                {w_hi, w_lo} = -w_prod_u;
            end
        end else begin
            if (r_neg_q && (r_b != '0)) begin
                w_lo = -w_prod_u[WIDTH-1:0];
            end
            if (r_neg_r) begin
                w_hi = -w_prod_u[2*WIDTH-1:WIDTH];
            end
        end
    end
`else
    always_comb begin
        w_hi = w_acc_nxt[2*WIDTH-1:WIDTH];
        w_lo = w_acc_nxt[WIDTH-1:0];
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_b      <= '0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_dz     <= 1'b0;
`ifdef MULTDIV_SIGNED_EN
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= c_DONE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_hi    <= w_hi;
                        r_lo    <= w_lo;
                        r_dz    <= r_is_div & (r_b == '0);
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request.
                    if (bus.start) begin
                        r_state  <= c_RUN;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_dz     <= 1'b0;
                        r_is_div <= bus.op[0];
                        r_b      <= w_b_in;
                        r_acc    <= {{(WIDTH+1){1'b0}}, w_a_in};
`ifdef MULTDIV_SIGNED_EN
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
`endif
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
    assign bus.div_by_zero = r_dz;

endmodule

`default_nettype wire

// File: tb/tb_multdiv_unit.sv
// ============================================================================
// Module      : tb_multdiv_unit
// Description : Directed self-checking bench for multdiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multdiv_unit;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    multdiv_unit_if #(.WIDTH(W)) bus();

    multdiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Returns edges until done (0 on timeout) and whether busy/hi/lo held before it.
    task automatic wait_done(output int cyc, output bit held);
        logic [W-1:0] h0, l0;
        h0 = bus.hi; l0 = bus.lo; held = 1'b1; cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                cyc = i;
                break;
            end
            if (bus.busy !== 1'b1 || bus.hi !== h0 || bus.lo !== l0) held = 1'b0;
        end
    endtask

    task automatic test_reset;
        #2 reset = 1'b1;
        #1;
        checks++; if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.done, bus.div_by_zero}); end
        checks++; if ({bus.hi, bus.lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo: got %h expected 0", {bus.hi, bus.lo}); end
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_multu;
        int cyc; bit held;
        launch(2'b00, 32'hFFFF_FFFF, 32'h0000_0002);
        checks++; if ({bus.busy, bus.done} !== 2'b10) begin errors++; $display("FAIL multu_start_busy: got %b expected 10", {bus.busy, bus.done}); end
        wait_done(cyc, held);
        checks++; if (cyc != 32) begin errors++; $display("FAIL multu_latency: got %0d expected 32", cyc); end
        checks++; if (!held) begin errors++; $display("FAIL multu_hold: got 0 expected 1"); end
        checks++; if (bus.hi !== 32'h0000_0001) begin errors++; $display("FAIL multu_hi: got %h expected 00000001", bus.hi); end
        checks++; if (bus.lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo: got %h expected fffffffe", bus.lo); end
        checks++; if ({bus.busy, bus.div_by_zero} !== 2'b00) begin errors++; $display("FAIL multu_flags: got %b expected 00", {bus.busy, bus.div_by_zero}); end
        @(posedge clk); #1;
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL multu_done_pulse: got %b expected 00", {bus.busy, bus.done}); end
    endtask

    task automatic test_divu;
        int cyc; bit held;
        launch(2'b01, 32'd100, 32'd7);
        wait_done(cyc, held);
        checks++; if (cyc != 32) begin errors++; $display("FAIL divu_latency: got %0d expected 32", cyc); end
        checks++; if ({bus.hi, bus.lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_result: got %h expected %h", {bus.hi, bus.lo}, {32'd2, 32'd14}); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL divu_dz: got %b expected 0", bus.div_by_zero); end
        launch(2'b01, 32'd5, 32'd0);
        wait_done(cyc, held);
        checks++; if (cyc != 32) begin errors++; $display("FAIL divz_latency: got %0d expected 32", cyc); end
        checks++; if ({bus.hi, bus.lo} !== {32'd5, 32'hFFFF_FFFF}) begin errors++; $display("FAIL divz_result: got %h expected %h", {bus.hi, bus.lo}, {32'd5, 32'hFFFF_FFFF}); end
        checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL divz_dz: got %b expected 1", bus.div_by_zero); end
        launch(2'b00, 32'd3, 32'd4);
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_clear: got %b expected 0", bus.div_by_zero); end
        wait_done(cyc, held);
        checks++; if ({bus.hi, bus.lo, bus.div_by_zero} !== {32'd0, 32'd12, 1'b0}) begin errors++; $display("FAIL multu_3x4: got %h expected %h", {bus.hi, bus.lo, bus.div_by_zero}, {32'd0, 32'd12, 1'b0}); end
`ifndef MULTDIV_SIGNED_EN
        launch(2'b11, 32'd100, 32'd7);
        wait_done(cyc, held);
        checks++; if ({bus.hi, bus.lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL op11_as_divu: got %h expected %h", {bus.hi, bus.lo}, {32'd2, 32'd14}); end
        launch(2'b10, 32'hFFFF_FFFF, 32'd2);
        wait_done(cyc, held);
        checks++; if ({bus.hi, bus.lo} !== {32'd1, 32'hFFFF_FFFE}) begin errors++; $display("FAIL op10_as_multu: got %h expected %h", {bus.hi, bus.lo}, {32'd1, 32'hFFFF_FFFE}); end
`endif
    endtask

    task automatic test_back_to_back;
        int cyc; bit held;
        launch(2'b01, 32'd100, 32'd7);
        bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd9; bus.op = 2'b00;
        wait_done(cyc, held);
        checks++; if (cyc != 32) begin errors++; $display("FAIL ignore_latency: got %0d expected 32", cyc); end
        checks++; if ({bus.hi, bus.lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL ignore_result: got %h expected %h", {bus.hi, bus.lo}, {32'd2, 32'd14}); end
        // start still high during DONE: new operands must be taken
        bus.a = 32'd6; bus.b = 32'd7; bus.op = 2'b00;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++; if ({bus.busy, bus.done} !== 2'b10) begin errors++; $display("FAIL b2b_accept: got %b expected 10", {bus.busy, bus.done}); end
        wait_done(cyc, held);
        checks++; if (cyc != 32) begin errors++; $display("FAIL b2b_latency: got %0d expected 32", cyc); end
        checks++; if ({bus.hi, bus.lo} !== {32'd0, 32'd42}) begin errors++; $display("FAIL b2b_result: got %h expected %h", {bus.hi, bus.lo}, {32'd0, 32'd42}); end
    endtask

    task automatic test_reset_mid_op;
        int cyc; bit held; int pulses;
        launch(2'b01, 32'd5, 32'd0);
        wait_done(cyc, held);
        launch(2'b01, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++; if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin errors++; $display("FAIL midrst_flags: got %b expected 000", {bus.busy, bus.done, bus.div_by_zero}); end
        checks++; if ({bus.hi, bus.lo} !== 64'h0) begin errors++; $display("FAIL midrst_hilo: got %h expected 0", {bus.hi, bus.lo}); end
        #2 reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_no_done: got %0d expected 0", pulses); end
        launch(2'b00, 32'd3, 32'd4);
        wait_done(cyc, held);
        checks++; if (cyc != 32) begin errors++; $display("FAIL postrst_latency: got %0d expected 32", cyc); end
        checks++; if ({bus.hi, bus.lo} !== {32'd0, 32'd12}) begin errors++; $display("FAIL postrst_result: got %h expected %h", {bus.hi, bus.lo}, {32'd0, 32'd12}); end
    endtask

`ifdef MULTDIV_SIGNED_EN
    task automatic test_signed;
        int cyc; bit held;
        launch(2'b10, 32'hFFFF_FFFD, 32'd5);
        wait_done(cyc, held);
        checks++; if (cyc != 32) begin errors++; $display("FAIL mult_latency: got %0d expected 32", cyc); end
        checks++; if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("FAIL mult_neg: got %h expected ffffffff_fffffff1", {bus.hi, bus.lo}); end
        launch(2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc, held);
        checks++; if ({bus.hi, bus.lo, bus.div_by_zero} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}) begin errors++; $display("FAIL div_neg: got %h expected %h", {bus.hi, bus.lo, bus.div_by_zero}, {32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}); end
        launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc, held);
        checks++; if ({bus.hi, bus.lo} !== {32'd0, 32'h8000_0000}) begin errors++; $display("FAIL div_minneg: got %h expected %h", {bus.hi, bus.lo}, {32'd0, 32'h8000_0000}); end
        launch(2'b11, 32'hFFFF_FFFB, 32'd0);
        wait_done(cyc, held);
        checks++; if ({bus.hi, bus.lo, bus.div_by_zero} !== {32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1}) begin errors++; $display("FAIL div_zero_signed: got %h expected %h", {bus.hi, bus.lo, bus.div_by_zero}, {32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1}); end
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        test_reset();
        test_multu();
        test_divu();
        test_back_to_back();
        test_reset_mid_op();
`ifdef MULTDIV_SIGNED_EN
        test_signed();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
